decoder4x16_strobe: RTL and testbench
=====================================

DECODER4X16_STROBE -- requirements
Module: decoder4x16_strobe

Interface
REQ-001 The block SHALL have parameter PULSE_LEN, default 4, giving the number of cycles the one-hot output is asserted; legal range 1..255.
REQ-002 The block SHALL have parameter GAP_LEN, default 1, giving the number of idle cycles (y=0, busy=1) after each pulse; legal range 0..255.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports clk and rst.
REQ-004 Port clk  input  1  rising-edge clock for all state.
REQ-005 Port rst  input  1  asynchronous active-high reset.
REQ-006 Port in_valid  input  1  a code is presented on code.
REQ-007 Port code  input  4  binary index to decode, 0..15.
REQ-008 Port in_ready  output  1  block can accept a code this cycle.
REQ-009 Port abort  input  1  synchronous request to terminate the current pulse/gap.
REQ-010 Port y  output  16  registered one-hot strobe; bit code is set during the pulse.
REQ-011 Port busy  output  1  high while in PULSE or GAP.
REQ-012 Port done  output  1  single-cycle flag marking normal completion of a pulse/gap sequence.

Function
REQ-013 The block SHALL implement a 3-state FSM: IDLE, PULSE, GAP.
REQ-014 in_ready SHALL equal 1 exactly when the state is IDLE (combinational from state only, no dependence on in_valid).
REQ-015 A transfer SHALL occur on a rising clk edge with in_valid=1 and in_ready=1; code is latched into an internal register at that edge.
REQ-016 On transfer, the next state SHALL be PULSE, with y = 16'h0001 << code and busy=1 starting the cycle after the transfer edge (1-cycle latency).
REQ-017 y SHALL contain exactly one set bit in PULSE and SHALL be all zeros in IDLE and GAP.
REQ-018 PULSE SHALL last exactly PULSE_LEN cycles, counted by a down-counter loaded on transfer.
REQ-019 After PULSE, the FSM SHALL enter GAP for exactly GAP_LEN cycles; if GAP_LEN=0, it SHALL go directly from PULSE to IDLE.
REQ-020 On the normal GAP->IDLE (or PULSE->IDLE when GAP_LEN=0) transition, done SHALL be 1 for exactly the first IDLE cycle; done SHALL be 0 at all other times.
REQ-021 Changes on code or in_valid while not in IDLE SHALL be ignored and SHALL NOT alter y.
REQ-022 abort=1 at a clk edge in PULSE or GAP SHALL force IDLE, y=0, busy=0, and counter=0 the next cycle, with done remaining 0.
REQ-023 abort SHALL be ignored in IDLE; in_valid=1 with abort=1 in IDLE SHALL still transfer.
REQ-024 Back-to-back: a transfer SHALL be accepted in the same IDLE cycle in which done=1, yielding exactly 1 IDLE cycle between sequences.
REQ-025 The counter SHALL be 8 bits wide and SHALL never wrap; it SHALL load PULSE_LEN-1 on transfer and GAP_LEN-1 on entering GAP.

Reset
REQ-026 While rst=1, regardless of clk, the block SHALL hold state=IDLE, y=16'h0000, busy=0, done=0, in_ready=1, counter=0, and latched code=0.
REQ-027 rst asserted mid-PULSE or mid-GAP SHALL clear y and busy immediately (asynchronously) without producing done.
REQ-028 After rst deasserts, the first transfer SHALL be possible at the first rising clk edge.

Verification
REQ-029 Default parameters, with code=5 and a 1-cycle in_valid -> y=16'h0020 for 4 cycles, then y=0/busy=1 for 1 cycle, then done=1 for 1 cycle, and in_ready=1 again.
REQ-030 Sweep of code 0..15 back-to-back, each transfer taken on the done cycle -> each y equals 1<<code, and exactly one set bit is checked every PULSE cycle.
REQ-031 With code=15 and abort pulsed in the 2nd PULSE cycle -> y=0 and in_ready=1 the next cycle, with done never asserted.
REQ-032 With PULSE_LEN=1, GAP_LEN=0, and code=0 -> y=16'h0001 for 1 cycle, then done=1 the following cycle.
REQ-033 With code=9 and in_valid held high while code toggles during PULSE -> y stays 16'h0200 and no second transfer occurs until IDLE.
REQ-034 rst asserted mid-PULSE (code=3), between clock edges -> y=0 and busy=0 before the next edge, done=0, and normal operation resumes after release.

Source files
------------

// File: rtl/decoder4x16_strobe.sv
// 4-to-16 one-hot strobe generator: a accepted code drives a one-hot pulse of
// PULSE_LEN cycles, followed by GAP_LEN idle-but-busy cycles and a done flag.
module decoder4x16_strobe #(
   parameter int PULSE_LEN = 4,
   parameter int GAP_LEN   = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [3:0]  code,
   output logic        in_ready,
   input  logic        abort,
   output logic [15:0] y,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } state_t;

   // Counter reload values; the count runs down to zero so it never wraps.
   localparam logic [7:0] PULSE_LD = 8'(PULSE_LEN - 1);
   localparam logic [7:0] GAP_LD   = (GAP_LEN > 0) ? 8'(GAP_LEN - 1) : 8'd0;

   state_t     state;
   logic [7:0] cnt;
   logic [3:0] code_q;

   function automatic logic [15:0] onehot(input logic [3:0] idx);
      return 16'h0001 << idx;
   endfunction

   assign in_ready = (state == IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= 8'd0;
         code_q <= 4'd0;
         y      <= 16'h0000;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // abort has no meaning here, so a transfer proceeds regardless
               if (in_valid) begin
                  state  <= PULSE;
                  code_q <= code;
                  y      <= onehot(code);
                  busy   <= 1'b1;
                  cnt    <= PULSE_LD;
               end
            end
            PULSE: begin
               if (abort) begin
                  state <= IDLE;
                  y     <= 16'h0000;
                  busy  <= 1'b0;
                  cnt   <= 8'd0;
               end else if (cnt == 8'd0) begin
                  y <= 16'h0000;
                  if (GAP_LEN == 0) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= GAP;
                     cnt   <= GAP_LD;
                  end
               end else begin
                  cnt <= cnt - 8'd1;
                  y   <= onehot(code_q);
               end
            end
            GAP: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  cnt   <= 8'd0;
               end else if (cnt == 8'd0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt - 8'd1;
               end
               y <= 16'h0000;
            end
            default: begin
               state <= IDLE;
               y     <= 16'h0000;
               busy  <= 1'b0;
               cnt   <= 8'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_decoder4x16_strobe.sv
// Directed bench for decoder4x16_strobe: default instance plus a
// PULSE_LEN=1 / GAP_LEN=0 instance.
module tb_decoder4x16_strobe;

   logic        clk;
   logic        rst;
   logic        in_valid, abort;
   logic [3:0]  code;
   logic        in_ready, busy, done;
   logic [15:0] y;
   logic        in_valid_s, abort_s;
   logic [3:0]  code_s;
   logic        in_ready_s, busy_s, done_s;
   logic [15:0] y_s;

   int errors = 0;
   int checks = 0;

   decoder4x16_strobe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .code(code), .in_ready(in_ready),
      .abort(abort), .y(y), .busy(busy), .done(done)
   );

   decoder4x16_strobe #(.PULSE_LEN(1), .GAP_LEN(0)) dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid_s), .code(code_s), .in_ready(in_ready_s),
      .abort(abort_s), .y(y_s), .busy(busy_s), .done(done_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; abort = 1'b0; code = 4'd0;
      in_valid_s = 1'b0; abort_s = 1'b0; code_s = 4'd0;
      #2;
      checks++; if (y !== 16'h0000) begin errors++; $display("FAIL reset_y: got %h expected 0000", y); end
      checks++; if ({busy, done, in_ready} !== 3'b001) begin errors++; $display("FAIL reset_flags: got %b expected 001", {busy, done, in_ready}); end
      tick(); tick();
      checks++; if ({y_s, busy_s, done_s, in_ready_s} !== {16'h0000, 3'b001}) begin errors++; $display("FAIL reset_short: got %h/%b expected 0000/001", y_s, {busy_s, done_s, in_ready_s}); end
      // first edge after release already transfers
      rst = 1'b0; in_valid = 1'b1; code = 4'd2;
      tick();
      in_valid = 1'b0;
      checks++; if (y !== 16'h0004) begin errors++; $display("FAIL reset_first_xfer: got %h expected 0004", y); end
      repeat (5) tick();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL reset_first_done: got %b expected 1", done); end
      tick();
   endtask

   task automatic test_basic();
      in_valid = 1'b1; code = 4'd5;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if ({y, busy, in_ready, done} !== {16'h0020, 3'b100}) begin errors++; $display("FAIL basic_pulse%0d: got %h/%b expected 0020/100", i, y, {busy, in_ready, done}); end
         tick();
      end
      checks++; if ({y, busy, in_ready, done} !== {16'h0000, 3'b100}) begin errors++; $display("FAIL basic_gap: got %h/%b expected 0000/100", y, {busy, in_ready, done}); end
      tick();
      checks++; if ({y, busy, in_ready, done} !== {16'h0000, 3'b011}) begin errors++; $display("FAIL basic_done: got %h/%b expected 0000/011", y, {busy, in_ready, done}); end
      tick();
      checks++; if ({busy, in_ready, done} !== 3'b010) begin errors++; $display("FAIL basic_idle: got %b expected 010", {busy, in_ready, done}); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp;
      for (int c = 0; c < 16; c++) begin
         if (c > 0) begin
            checks++; if ({done, in_ready} !== 2'b11) begin errors++; $display("FAIL b2b_done%0d: got %b expected 11", c, {done, in_ready}); end
         end
         in_valid = 1'b1; code = 4'(c);
         tick();
         in_valid = 1'b0;
         exp = 16'h0001 << c;
         for (int i = 0; i < 4; i++) begin
            checks++; if (y !== exp) begin errors++; $display("FAIL b2b_y%0d_%0d: got %h expected %h", c, i, y, exp); end
            checks++; if ($countones(y) != 1) begin errors++; $display("FAIL b2b_onehot%0d_%0d: got %0d bits expected 1", c, i, $countones(y)); end
            tick();
         end
         tick();
      end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_last_done: got %b expected 1", done); end
      tick();
   endtask

   task automatic test_abort();
      in_valid = 1'b1; code = 4'd15;
      tick();
      in_valid = 1'b0;
      tick();
      checks++; if (y !== 16'h8000) begin errors++; $display("FAIL abort_pulse2: got %h expected 8000", y); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++; if ({y, in_ready, busy, done} !== {16'h0000, 3'b100}) begin errors++; $display("FAIL abort_idle: got %h/%b expected 0000/100", y, {in_ready, busy, done}); end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_nodone%0d: got %b expected 0", i, done); end
      end
      // abort during the gap
      in_valid = 1'b1; code = 4'd1;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      checks++; if ({y, busy} !== {16'h0000, 1'b1}) begin errors++; $display("FAIL abort_gap_pre: got %h/%b expected 0000/1", y, busy); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++; if ({busy, done, in_ready} !== 3'b001) begin errors++; $display("FAIL abort_gap: got %b expected 001", {busy, done, in_ready}); end
      // abort is ignored in IDLE
      in_valid = 1'b1; abort = 1'b1; code = 4'd7;
      tick();
      in_valid = 1'b0; abort = 1'b0;
      checks++; if ({y, busy} !== {16'h0080, 1'b1}) begin errors++; $display("FAIL abort_in_idle: got %h/%b expected 0080/1", y, busy); end
      repeat (5) tick();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_in_idle_done: got %b expected 1", done); end
      tick();
   endtask

   task automatic test_hold();
      in_valid = 1'b1; code = 4'd9;
      tick();
      for (int i = 0; i < 4; i++) begin
         code = 4'(i * 3 + 1);
         checks++; if ({y, in_ready} !== {16'h0200, 1'b0}) begin errors++; $display("FAIL hold_pulse%0d: got %h/%b expected 0200/0", i, y, in_ready); end
         tick();
      end
      checks++; if ({y, busy} !== {16'h0000, 1'b1}) begin errors++; $display("FAIL hold_gap: got %h/%b expected 0000/1", y, busy); end
      tick();
      checks++; if ({done, in_ready, y} !== {2'b11, 16'h0000}) begin errors++; $display("FAIL hold_done: got %b/%h expected 11/0000", {done, in_ready}, y); end
      in_valid = 1'b0;
      tick();
      checks++; if ({y, busy} !== {16'h0000, 1'b0}) begin errors++; $display("FAIL hold_idle: got %h/%b expected 0000/0", y, busy); end
   endtask

   task automatic test_short();
      in_valid_s = 1'b1; code_s = 4'd0;
      tick();
      in_valid_s = 1'b0;
      checks++; if ({y_s, busy_s, done_s} !== {16'h0001, 2'b10}) begin errors++; $display("FAIL short_pulse: got %h/%b expected 0001/10", y_s, {busy_s, done_s}); end
      tick();
      checks++; if ({y_s, busy_s, done_s, in_ready_s} !== {16'h0000, 3'b011}) begin errors++; $display("FAIL short_done: got %h/%b expected 0000/011", y_s, {busy_s, done_s, in_ready_s}); end
      tick();
      checks++; if (done_s !== 1'b0) begin errors++; $display("FAIL short_done_once: got %b expected 0", done_s); end
   endtask

   task automatic test_rst_mid();
      in_valid = 1'b1; code = 4'd3;
      tick();
      in_valid = 1'b0;
      tick();
      checks++; if (y !== 16'h0008) begin errors++; $display("FAIL rstmid_pre: got %h expected 0008", y); end
      #2 rst = 1'b1;
      #1;
      checks++; if ({y, busy, done, in_ready} !== {16'h0000, 3'b001}) begin errors++; $display("FAIL rstmid_async: got %h/%b expected 0000/001", y, {busy, done, in_ready}); end
      tick();
      checks++; if ({y, done} !== {16'h0000, 1'b0}) begin errors++; $display("FAIL rstmid_hold: got %h/%b expected 0000/0", y, done); end
      rst = 1'b0;
      tick();
      checks++; if ({done, in_ready} !== 2'b01) begin errors++; $display("FAIL rstmid_release: got %b expected 01", {done, in_ready}); end
      in_valid = 1'b1; code = 4'd3;
      tick();
      in_valid = 1'b0;
      checks++; if (y !== 16'h0008) begin errors++; $display("FAIL rstmid_resume: got %h expected 0008", y); end
      repeat (5) tick();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL rstmid_resume_done: got %b expected 1", done); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_abort();
      test_hold();
      test_short();
      test_rst_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
